// File: rtl/spi_pkg.sv
// Shared types and bit-order helpers for the single-byte SPI master.
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TRAIL
  } spi_state_e;

  // Bit that goes out on mosi next, given the current TX shift register.
  function automatic logic first_bit(input logic [SPI_BITS-1:0] d, input logic lsb_first);
    return lsb_first ? d[0] : d[SPI_BITS-1];
  endfunction

  function automatic logic [SPI_BITS-1:0] tx_shift(input logic [SPI_BITS-1:0] d,
                                                   input logic lsb_first);
    return lsb_first ? {1'b0, d[SPI_BITS-1:1]} : {d[SPI_BITS-2:0], 1'b0};
  endfunction

  // LSB-first bits enter at the MSB so the first bit lands in bit 0 after 8 samples.
  function automatic logic [SPI_BITS-1:0] rx_shift(input logic [SPI_BITS-1:0] d,
                                                   input logic b,
                                                   input logic lsb_first);
    return lsb_first ? {b, d[SPI_BITS-1:1]} : {d[SPI_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Down-counter measuring one SCLK half-period; tick marks the last cycle of it.
module spi_halfperiod_timer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LOAD = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_reg;

  // Holds at zero once expired rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= 8'd0;
    end else if (restart) begin
      cnt_reg <= LOAD;
    end else if (cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign tick = (cnt_reg == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 single-byte SPI master: FSM, shift registers and bit counter.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  spi_state_e          state_reg;
  logic [SPI_BITS-1:0] tx_sr_reg;
  logic [SPI_BITS-1:0] rx_sr_reg;
  logic [SPI_BITS-1:0] tx_next;
  logic [2:0]          bit_cnt_reg;
  logic                tick;
  logic                restart;

  // Every non-idle state leaves on tick, so reloading on tick reloads on each transition.
  assign restart = (state_reg == IDLE) || tick;
  assign tx_next = tx_shift(tx_sr_reg, LSB_FIRST);

  spi_halfperiod_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      bit_cnt_reg <= 3'd0;
      cs          <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rx_data     <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            tx_sr_reg   <= tx_data;
            rx_sr_reg   <= '0;
            bit_cnt_reg <= 3'd0;
            cs          <= 1'b0;
            busy        <= 1'b1;
            mosi        <= first_bit(tx_data, LSB_FIRST);
            state_reg   <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (tick) begin
            sclk      <= 1'b1;
            rx_sr_reg <= rx_shift(rx_sr_reg, miso, LSB_FIRST);
            state_reg <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= TRAIL;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_sr_reg   <= tx_next;
              mosi        <= first_bit(tx_next, LSB_FIRST);
              state_reg   <= LOW;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            cs        <= 1'b1;
            busy      <= 1'b0;
            mosi      <= 1'b0;
            rx_data   <= rx_sr_reg;
            done      <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: loopback master (HALF_PERIOD=1, LSB first) and slave-model master (3, MSB first).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tx_a = 8'h00, tx_b = 8'h00;
  logic       busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic       busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;
  logic [7:0] rx_a, rx_b;
  logic [7:0] slv_b = 8'h00;
  logic       sel_b = 1'b0;
  logic       m_cs, m_busy, m_sclk, m_mosi, m_done;
  logic [7:0] m_rx;
  int         n_cmp = 0;
  int         n_err = 0;

  spi_master #(.HALF_PERIOD(1), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .busy(busy_a), .done(done_a),
    .rx_data(rx_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(mosi_a)
  );

  spi_master #(.HALF_PERIOD(3), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
    .rx_data(rx_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
  );

  initial forever #5 clk = ~clk;

  // Mode-0 slave returning 8'h3C MSB first: first bit on cs fall, next on each sclk fall.
  assign miso_b = slv_b[7];
  always @(negedge cs_b) slv_b = 8'h3C;
  always @(negedge sclk_b) if (!cs_b) slv_b = slv_b << 1;

  assign m_cs   = sel_b ? cs_b   : cs_a;
  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_sclk = sel_b ? sclk_b : sclk_a;
  assign m_mosi = sel_b ? mosi_b : mosi_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_rx   = sel_b ? rx_b   : rx_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One transfer; cycle 1 is the cycle after the accepting edge. glitch_cyc pulses start_a with FF.
  task automatic run_xfer(input bit which, input logic [7:0] data, input int glitch_cyc,
                          output int done_cyc, output int cs_low, output int busy_cyc,
                          output int rises, output logic [7:0] mosi_seq, output logic [7:0] rx);
    logic prev_sclk;
    prev_sclk = 1'b0;
    done_cyc = -1; cs_low = 0; busy_cyc = 0; rises = 0; mosi_seq = 8'h00; rx = 8'h00;
    sel_b = which;
    @(negedge clk);
    if (which) begin start_b = 1'b1; tx_b = data; end
    else begin start_a = 1'b1; tx_a = data; end
    @(negedge clk);
    if (which) begin start_b = 1'b0; tx_b = ~data; end
    else begin start_a = 1'b0; tx_a = ~data; end
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc == glitch_cyc) begin start_a = 1'b1; tx_a = 8'hFF; end
      else if (cyc == glitch_cyc + 1) start_a = 1'b0;
      if (!m_cs) cs_low++;
      if (m_busy) busy_cyc++;
      if (m_sclk && !prev_sclk) begin
        if (rises < 8) mosi_seq[3'(rises)] = m_mosi;
        rises++;
      end
      prev_sclk = m_sclk;
      if (m_done) begin
        done_cyc = cyc;
        rx = m_rx;
        break;
      end
      @(negedge clk);
    end
    $display("xfer dut=%s tx=%02h rx=%02h done_cyc=%0d cs_low=%0d rises=%0d",
             which ? "b" : "a", data, rx, done_cyc, cs_low, rises);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, csl, bc, rs, nd, d1, d2, f2, xd, xc;
    logic [7:0] ms, rx, r1, r2;
    logic prev;

    // Reset and idle outputs.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", {cs_a, sclk_a, mosi_a, busy_a, done_a, cs_b, sclk_b, mosi_b, busy_b, done_b},
            10'b10000_10000);
      check("idle_rx", {rx_a, rx_b}, 16'h0000);
    end

    // Loopback A5, LSB first, HALF_PERIOD=1.
    run_xfer(1'b0, 8'hA5, 0, dc, csl, bc, rs, ms, rx);
    check("lb_done_cyc", dc, 18);
    check("lb_cs_low", csl, 17);
    check("lb_busy", bc, 17);
    check("lb_rises", rs, 8);
    check("lb_mosi_seq", ms, 8'hA5);
    check("lb_rx", rx, 8'hA5);
    @(negedge clk);
    check("lb_done_pulse_end", {done_a, cs_a}, 2'b01);

    // Slave model 3C, MSB first, HALF_PERIOD=3; TX 96 goes out as 1,0,0,1,0,1,1,0.
    run_xfer(1'b1, 8'h96, 0, dc, csl, bc, rs, ms, rx);
    check("sl_done_cyc", dc, 52);
    check("sl_cs_low", csl, 51);
    check("sl_busy", bc, 51);
    check("sl_rises", rs, 8);
    check("sl_mosi_seq", ms, 8'h69);
    check("sl_rx", rx, 8'h3C);

    // start with FF mid-transfer of 12 is ignored.
    run_xfer(1'b0, 8'h12, 5, dc, csl, bc, rs, ms, rx);
    check("gl_done_cyc", dc, 18);
    check("gl_rx", rx, 8'h12);
    check("gl_mosi_seq", ms, 8'h12);
    xd = 0; xc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) xd++;
      if (!cs_a) xc++;
    end
    check("gl_no_2nd_done", xd, 0);
    check("gl_no_2nd_cs", xc, 0);

    // start held high: 01 then 80 back-to-back.
    sel_b = 1'b0;
    @(negedge clk); start_a = 1'b1; tx_a = 8'h01;
    @(negedge clk); tx_a = 8'h80;
    nd = 0; d1 = -1; d2 = -1; f2 = -1; r1 = 8'h00; r2 = 8'h00;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 19) start_a = 1'b0;
      if (done_a) begin
        nd++;
        if (nd == 1) begin d1 = cyc; r1 = rx_a; end
        else begin d2 = cyc; r2 = rx_a; end
      end
      if (nd == 1 && !cs_a && f2 < 0) f2 = cyc;
      @(negedge clk);
    end
    check("b2b_done1_cyc", d1, 18);
    check("b2b_rx1", r1, 8'h01);
    check("b2b_cs2_fall", f2, 19);
    check("b2b_done2_cyc", d2, 36);
    check("b2b_rx2", r2, 8'h80);
    check("b2b_done_count", nd, 2);

    // Async reset at the 4th sclk rise.
    @(negedge clk); start_a = 1'b1; tx_a = 8'h5A;
    @(negedge clk); start_a = 1'b0;
    rs = 0; xd = 0; prev = 1'b0;
    for (int cyc = 1; cyc <= 40 && rs < 4; cyc++) begin
      if (sclk_a && !prev) rs++;
      prev = sclk_a;
      if (done_a) xd++;
      if (rs < 4) @(negedge clk);
    end
    check("rst_saw_4th_rise", rs, 4);
    rst = 1'b0;
    #1;
    check("rst_async_outs", {cs_a, sclk_a, mosi_a, busy_a, done_a}, 5'b10000);
    check("rst_async_rx", rx_a, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done_a || !cs_a) xd++;
    end
    check("rst_no_done", xd, 0);
    run_xfer(1'b0, 8'hC3, 0, dc, csl, bc, rs, ms, rx);
    check("rst_after_done_cyc", dc, 18);
    check("rst_after_rx", rx, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
